// File: rtl/ps_loop_ctrl.sv
`timescale 1ns/1ps
// ps_loop_ctrl: zero-overhead DO-UNTIL loop controller for the fetch stage.
// Holds a stack of nested loops. Only the innermost loop is compared with
// the fetch address. At its end address the controller either redirects
// fetch back to the loop start or retires the loop.
//
// Handshake note: this block has no valid/ready pairs. lp_push, lp_pop and
// fetch_en are single-cycle qualifiers sampled at the clk_fetch edge.
// lp_redirect is a combinational request that the fetch register consumes
// at that same edge. Nothing is held or stalled here.
module ps_loop_ctrl #(
  parameter int AW    = 16,
  parameter int CW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk_fetch,
  input  logic                         rst,
  input  logic                         lp_push,
  input  logic [AW-1:0]                lp_start_add,
  input  logic [AW-1:0]                lp_end_add,
  input  logic [CW-1:0]                lp_count,
  input  logic                         lp_pop,
  input  logic [AW-1:0]                ps_faddr,
  input  logic                         fetch_en,
  input  logic                         flush,
  output logic                         lp_redirect,
  output logic [AW-1:0]                lp_redirect_add,
  output logic                         lp_active,
  output logic [CW-1:0]                lp_cntr,
  output logic [$clog2(DEPTH+1)-1:0]   lp_depth,
  output logic                         lp_ovf,
  output logic                         lp_unf,
  output logic [1:0]                   dbg_state
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]    state_q;
  logic [DW-1:0] depth_q;
  logic [AW-1:0] start_q [DEPTH];
  logic [AW-1:0] end_q   [DEPTH];
  logic [CW-1:0] cnt_q   [DEPTH];
  logic          ovf_q;
  logic          unf_q;

  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;
  logic [AW-1:0] top_start;
  logic [AW-1:0] top_end;
  logic [CW-1:0] top_cnt;
  logic          end_hit;
  logic          retire;
  logic          dec;
  logic          skip;
  logic          do_pop;
  logic          do_push;
  logic          ovf_set;
  logic [DW-1:0] depth_mid;

  // Decode this cycle's loop events. Pops are applied before the push, so the
  // push slot is computed from the post-pop depth.
  always_comb begin
    top_idx   = IW'(depth_q - DW'(1));
    top_start = start_q[top_idx];
    top_end   = end_q[top_idx];
    top_cnt   = cnt_q[top_idx];
    end_hit   = (state_q == ST_RUN) && fetch_en && !flush && (ps_faddr == top_end);
    // A resident counter is never below 1, so "not 1" means "more to go".
    retire    = end_hit && (top_cnt == CW'(1));
    dec       = end_hit && !lp_pop && (top_cnt > CW'(1));
    skip      = (state_q != ST_HALT) && lp_push && (lp_count == '0) && fetch_en && !flush;
    do_pop    = (state_q == ST_RUN) && (lp_pop || retire);
    depth_mid = depth_q - DW'(do_pop);
    wr_idx    = IW'(depth_mid);
    do_push   = (state_q != ST_HALT) && lp_push && (lp_count != '0);
    ovf_set   = do_push && (depth_mid == DW'(DEPTH));
  end

  // Redirect request for the fetch register. A zero-count skip takes priority
  // because the DO-UNTIL being decoded is older than the fetch address.
  always_comb begin
    lp_redirect     = 1'b0;
    lp_redirect_add = '0;
    if (rst) begin
      if (skip) begin
        lp_redirect     = 1'b1;
        lp_redirect_add = lp_end_add + AW'(1);
      end else if (dec) begin
        lp_redirect     = 1'b1;
        lp_redirect_add = top_start;
      end
    end
  end

  // Stack, counter, depth, FSM and sticky flags. HALT freezes everything
  // until reset.
  always_ff @(posedge clk_fetch or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else if (state_q != ST_HALT) begin
      if (lp_pop && (state_q == ST_EMPTY)) begin
        unf_q <= 1'b1;
      end
      if (dec) begin
        cnt_q[top_idx] <= top_cnt - CW'(1);
      end
      if (ovf_set) begin
        ovf_q   <= 1'b1;
        state_q <= ST_HALT;
      end else if (do_push) begin
        start_q[wr_idx] <= lp_start_add;
        end_q[wr_idx]   <= lp_end_add;
        cnt_q[wr_idx]   <= lp_count;
        depth_q         <= depth_mid + DW'(1);
        state_q         <= ST_RUN;
      end else begin
        depth_q <= depth_mid;
        state_q <= (depth_mid == '0) ? ST_EMPTY : ST_RUN;
      end
    end
  end

  // Registered status views.
  always_comb begin
    lp_active = (state_q == ST_RUN);
    lp_cntr   = (depth_q != '0) ? top_cnt : '0;
    lp_depth  = depth_q;
    lp_ovf    = ovf_q;
    lp_unf    = unf_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_ps_loop_ctrl.sv
`timescale 1ns/1ps
// Bench for ps_loop_ctrl: directed loop scenarios followed by random
// traffic. A loop-stack reference model predicts every cycle's outputs.
module tb_ps_loop_ctrl;

  localparam int AW    = 16;
  localparam int CW    = 16;
  localparam int DEPTH = 4;
  localparam int DW    = 3;
  localparam int EW    = 1 + AW + 1 + CW + DW + 1 + 1;

  logic          clk_fetch;
  logic          rst;
  logic          lp_push;
  logic [AW-1:0] lp_start_add;
  logic [AW-1:0] lp_end_add;
  logic [CW-1:0] lp_count;
  logic          lp_pop;
  logic [AW-1:0] ps_faddr;
  logic          fetch_en;
  logic          flush;
  logic          lp_redirect;
  logic [AW-1:0] lp_redirect_add;
  logic          lp_active;
  logic [CW-1:0] lp_cntr;
  logic [DW-1:0] lp_depth;
  logic          lp_ovf;
  logic          lp_unf;
  logic [1:0]    dbg_state;

  ps_loop_ctrl #(.AW(AW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk_fetch(clk_fetch), .rst(rst),
    .lp_push(lp_push), .lp_start_add(lp_start_add), .lp_end_add(lp_end_add),
    .lp_count(lp_count), .lp_pop(lp_pop), .ps_faddr(ps_faddr),
    .fetch_en(fetch_en), .flush(flush),
    .lp_redirect(lp_redirect), .lp_redirect_add(lp_redirect_add),
    .lp_active(lp_active), .lp_cntr(lp_cntr), .lp_depth(lp_depth),
    .lp_ovf(lp_ovf), .lp_unf(lp_unf), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk_fetch = 1'b0;
  always #5 clk_fetch = ~clk_fetch;

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] s;
    logic [AW-1:0] e;
    logic [CW-1:0] c;
  } ent_t;

  ent_t           m_stack[$];
  bit             m_halt;
  bit             m_ovf;
  bit             m_unf;

  logic [EW-1:0]  exp_q[$];
  int             checks;
  int             failures;

  function automatic logic [EW-1:0] pack(input logic rd, input logic [AW-1:0] ra,
                                         input logic act, input logic [CW-1:0] cn,
                                         input logic [DW-1:0] dp, input logic ov,
                                         input logic un);
    return {rd, ra, act, cn, dp, ov, un};
  endfunction

  task automatic model_reset();
    m_stack.delete();
    m_halt = 0;
    m_ovf  = 0;
    m_unf  = 0;
  endtask

  // ---------------- driver ----------------
  // One fetch cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input logic push, input logic [AW-1:0] st, input logic [AW-1:0] en,
                      input logic [CW-1:0] cnt, input logic pop, input logic [AW-1:0] fa,
                      input logic fen, input logic fl);
    ent_t          top;
    bit            has;
    bit            hit;
    logic          rd;
    logic [AW-1:0] ra;
    @(posedge clk_fetch);
    #1;
    lp_push = push; lp_start_add = st; lp_end_add = en; lp_count = cnt;
    lp_pop = pop; ps_faddr = fa; fetch_en = fen; flush = fl;

    has = (m_stack.size() > 0);
    top = '{s: '0, e: '0, c: '0};
    if (has) top = m_stack[m_stack.size()-1];
    hit = !m_halt && has && fen && !fl && (fa == top.e);
    rd = 0;
    ra = '0;
    if (!m_halt && push && cnt == 0 && fen && !fl) begin
      rd = 1;
      ra = en + 16'd1;
    end else if (hit && !pop && top.c > 1) begin
      rd = 1;
      ra = top.s;
    end
    exp_q.push_back(pack(rd, ra, !m_halt && has, has ? top.c : '0,
                         DW'(m_stack.size()), m_ovf, m_unf));

    if (!m_halt) begin
      if (pop && !has) m_unf = 1;
      if (has && (pop || (hit && top.c == 1))) begin
        void'(m_stack.pop_back());
      end else if (hit && !pop) begin
        top = m_stack.pop_back();
        top.c = top.c - 1;
        m_stack.push_back(top);
      end
      if (push && cnt != 0) begin
        if (m_stack.size() == DEPTH) begin
          m_halt = 1;
          m_ovf  = 1;
        end else begin
          m_stack.push_back('{s: st, e: en, c: cnt});
        end
      end
    end
  endtask

  task automatic fetch(input logic [AW-1:0] fa);
    step(0, '0, '0, '0, 0, fa, 1, 0);
  endtask

  task automatic push_loop(input logic [AW-1:0] st, input logic [AW-1:0] en,
                           input logic [CW-1:0] cnt, input logic [AW-1:0] fa);
    step(1, st, en, cnt, 0, fa, 1, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    logic [EW-1:0] got;
    @(negedge clk_fetch);
    #2;
    rst = 1'b0;
    #1;
    got = pack(lp_redirect, lp_redirect_add, lp_active, lp_cntr, lp_depth, lp_ovf, lp_unf);
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", got);
    end
    lp_push = 0; lp_start_add = '0; lp_end_add = '0; lp_count = '0;
    lp_pop = 0; ps_faddr = '0; fetch_en = 0; flush = 0;
    model_reset();
    @(posedge clk_fetch);
    #2;
    rst = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_fetch) begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = pack(lp_redirect, lp_redirect_add, lp_active, lp_cntr, lp_depth, lp_ovf, lp_unf);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t got rd=%b ra=%h act=%b cntr=%h depth=%0d ovf=%b unf=%b required rd=%b ra=%h act=%b cntr=%h depth=%0d ovf=%b unf=%b",
                 $time, got[EW-1], got[EW-2 -: AW], got[EW-2-AW], got[CW+DW+1 -: CW],
                 got[DW+1 -: DW], got[1], got[0],
                 e[EW-1], e[EW-2 -: AW], e[EW-2-AW], e[CW+DW+1 -: CW],
                 e[DW+1 -: DW], e[1], e[0]);
      end
    end
  end

  // Global time bound.
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] st;
    logic [AW-1:0] fa;
    checks = 0;
    failures = 0;
    model_reset();
    rst = 1'b0;
    lp_push = 0; lp_start_add = '0; lp_end_add = '0; lp_count = '0;
    lp_pop = 0; ps_faddr = '0; fetch_en = 0; flush = 0;
    repeat (2) @(posedge clk_fetch);
    #2;
    rst = 1'b1;

    // Simple loop: 3 iterations of 0x10..0x13.
    fetch(16'h0000);
    push_loop(16'h0010, 16'h0013, 16'd3, 16'h000F);
    for (int it = 0; it < 3; it++)
      for (int a = 'h10; a <= 'h13; a++) fetch(AW'(a));
    fetch(16'h0014);

    // Nested loops.
    push_loop(16'h0020, 16'h0028, 16'd2, 16'h001F);
    fetch(16'h0020);
    push_loop(16'h0022, 16'h0024, 16'd2, 16'h0021);
    for (int it = 0; it < 2; it++)
      for (int a = 'h22; a <= 'h24; a++) fetch(AW'(a));
    for (int a = 'h25; a <= 'h28; a++) fetch(AW'(a));
    for (int a = 'h20; a <= 'h28; a++) fetch(AW'(a));
    fetch(16'h0029);

    // Zero-count skip wraps the target address.
    step(1, 16'hFFF0, 16'hFFFF, 16'd0, 0, 16'hFFEF, 1, 0);
    step(1, 16'h0100, 16'h0105, 16'd0, 0, 16'h0050, 1, 1);
    fetch(16'h0000);

    // Fill the stack, overflow into HALT, then underflow after reset.
    for (int i = 0; i < DEPTH; i++)
      push_loop(AW'('h100 + i*16), AW'('h10F + i*16), 16'd2, 16'h00F0);
    push_loop(16'h0200, 16'h0210, 16'd2, 16'h00F1);
    fetch(16'h013F);
    fetch(16'h013F);
    do_reset();
    step(0, '0, '0, '0, 1, 16'h0000, 1, 0);
    fetch(16'h0000);
    do_reset();

    // Same-cycle retire and push, then flush on an end hit.
    push_loop(16'h0030, 16'h0031, 16'd1, 16'h002F);
    fetch(16'h0030);
    push_loop(16'h0040, 16'h0041, 16'd5, 16'h0031);
    fetch(16'h0040);
    step(0, '0, '0, '0, 0, 16'h0041, 1, 1);
    fetch(16'h0041);
    fetch(16'h0040);
    step(0, '0, '0, '0, 1, 16'h0041, 1, 0);
    // Single-instruction loop.
    push_loop(16'h0060, 16'h0060, 16'd3, 16'h005F);
    repeat (4) fetch(16'h0060);

    // Reset mid-loop with counter 4.
    push_loop(16'h0050, 16'h0053, 16'd4, 16'h004F);
    fetch(16'h0050);
    do_reset();
    fetch(16'h0053);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 59) do_reset();
      st = AW'($urandom_range(0, 15));
      if (m_stack.size() > 0 && $urandom_range(0, 1) == 1)
        fa = m_stack[m_stack.size()-1].e;
      else
        fa = AW'($urandom_range(0, 20));
      step($urandom_range(0, 5) == 0, st, st + AW'($urandom_range(0, 3)),
           CW'($urandom_range(0, 3)), $urandom_range(0, 19) == 0, fa,
           $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
    end

    @(negedge clk_fetch);
    @(negedge clk_fetch);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps_loop_ctrl.md
# ps_loop_ctrl

Zero-overhead hardware-loop controller for the program sequencer's fetch stage. It holds a stack of up to DEPTH nested DO-UNTIL loops, each with a start address, end address and iteration counter. It compares the current fetch address with the innermost loop's end address. On a match it either redirects the next fetch back to the loop start or retires the loop, so loop bodies run with no branch penalty.

## Interface
- AW, 16, fetch-address width
- CW, 16, loop-counter width
- DEPTH, 4, loop-stack entries (≥2)
- clk_fetch  in  1  fetch clock, rising edge
- rst  in  1  asynchronous, active-low reset
- lp_push  in  1  DO-UNTIL decoded this cycle; push new loop
- lp_start_add  in  AW  first body address of pushed loop
- lp_end_add  in  AW  last body address of pushed loop
- lp_count  in  CW  iteration count of pushed loop
- lp_pop  in  1  explicit loop abort (pop top entry)
- ps_faddr  in  AW  current fetch address
- fetch_en  in  1  fetch advancing this cycle (not idle, not stack-locked)
- flush  in  1  jump/return/call in flight; suppresses loop action
- lp_redirect  out  1  next fetch address = lp_redirect_add
- lp_redirect_add  out  AW  redirect target
- lp_active  out  1  stack non-empty and not halted
- lp_cntr  out  CW  top-of-stack counter (0 when empty)
- lp_depth  out  $clog2(DEPTH+1)  valid entries
- lp_ovf  out  1  sticky stack overflow
- lp_unf  out  1  sticky stack underflow

## Operation
- FSM states: EMPTY (depth 0), RUN (depth ≥1), HALT (overflow lock).
- end_hit = (state==RUN) & fetch_en & !flush & (ps_faddr == top.end).
- end_hit with top.cntr > 1: lp_redirect=1, target = top.start; top.cntr decremented at the edge.
- end_hit with top.cntr == 1: no redirect; top entry popped at the edge (loop falls through to end+1).
- Push, lp_count ≥ 1: entry {start, end, count} written at depth; depth+1; EMPTY→RUN.
- Push, lp_count == 0: no push; lp_redirect=1, target = lp_end_add+1 (mod 2^AW), so the body is skipped. Skip is gated by !flush and fetch_en.
- Explicit pop: top discarded; depth−1; RUN→EMPTY when depth reaches 0.
- Simultaneous events, same edge, applied in order pop-type then push:
  - end_hit-retire or lp_pop removes the top, then lp_push writes the new top; depth is unchanged.
  - lp_pop together with end_hit: one pop only; no redirect.
- Push when depth==DEPTH and no same-cycle pop: lp_ovf←1, state→HALT. In HALT, lp_redirect=0 and lp_active=0 until reset.
- Pop/retire never occurs in EMPTY. lp_pop in EMPTY sets lp_unf←1 and leaves state unchanged.
- Only the top entry is compared. Nested loops sharing an end address are not supported; software guarantees distinct end addresses.
- start==end (single-instruction loop) is legal: redirect to the same address every cycle until the count expires.
- Address and counter arithmetic are modulo 2^AW / 2^CW. A counter never decrements below 1 while resident.

## Timing
- lp_redirect / lp_redirect_add are combinational from state, the top entry, ps_faddr, lp_push, lp_count, flush and fetch_en. The fetch register samples them at the same clk_fetch edge.
- Stack, counter, depth, state and sticky flags update on the rising clk_fetch edge.
- A pushed loop is compared from the cycle after the push edge. The DO-UNTIL instruction itself is never the end match.
- lp_cntr / lp_depth reflect the registered state; a change is visible one edge after its cause.
- Reset (async, any time, including mid-loop): state=EMPTY, depth=0, all entries cleared, lp_cntr=0, lp_redirect=0, lp_redirect_add=0, lp_active=0, lp_ovf=0, lp_unf=0. Release is synchronous to clk_fetch.
- flush asserted on an end_hit cycle: no redirect and no decrement. The loop state is kept for when fetch resumes.

## Test plan
- Push start=0x0010, end=0x0013, count=3; step ps_faddr 0x10..0x13 repeatedly -> redirect to 0x0010 at the first two 0x13 hits, lp_cntr 3→2→1, no redirect on the third hit, depth 1→0.
- Nested: outer {0x20,0x28,2}, inner {0x22,0x24,2} -> inner redirects once then retires, outer redirects once at 0x28, final depth 0, lp_active=0.
- Push with lp_count=0, lp_end_add=0xFFFF -> lp_redirect=1, target 0x0000, depth unchanged.
- Fill DEPTH=4 entries then push again -> lp_ovf=1, HALT, lp_redirect stays 0 on a later end match; then lp_pop in EMPTY after reset -> lp_unf=1.
- Same-cycle end_hit retire and push {0x40,0x41,5} -> depth unchanged, new top counter 5. Then flush on an end_hit -> no redirect, lp_cntr holds.
- Assert rst mid-loop (counter 4) -> all outputs zero immediately. After release, ps_faddr at the old end address -> no redirect.
